// File: rtl/ddr3_rw_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_pkg
//  Description : Shared definitions for the DDR3 frame-buffer read/write
//                arbiter: MIG app_cmd encodings, the arbiter state type and
//                the FIFO occupancy count width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr3_pkg;

    // Width of the FIFO occupancy counts and of the burst beat counter
    localparam int FIFO_CNT_W = 11;

    // MIG user-interface command encodings
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Arbiter states
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr3_rw_arb_load_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : load_edge_sync
//  Description : Two-flop synchronizer for an asynchronous level input,
//                followed by a rising-edge detector producing a one-cycle
//                pulse in the destination clock domain.
//  Ports       : clk      - destination clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous level input
//                o_pulse  - one-cycle pulse on each synchronized rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module load_edge_sync
    import ddr3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/ddr3_rw_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_rw_arb
//  Description : Frame-buffer traffic controller between a write/read FIFO
//                pair and the MIG user (app_*) interface. Arbitrates
//                fixed-length write and read bursts (writes first), generates
//                wrapping DDR3 addresses and the FIFO pop/push strobes.
//                Entirely in the MIG UI clock domain.
//  Options     : PINGPONG_EN - two frame banks selected by app_addr[BANK_BIT];
//                the read bank follows the opposite of the write bank.
//  Ports       : clk_100, rst            - UI clock, sync active-high reset
//                init_calib_complete     - MIG calibration done
//                app_rdy, app_wdf_rdy    - MIG command / write-data accept
//                app_rd_data_valid       - MIG read data valid
//                wfifo_rcount            - words available in write FIFO
//                rfifo_wcount            - words held in read FIFO
//                wr_load, rd_load        - async frame restarts
//                app_addr/app_cmd/app_en - MIG command channel
//                app_wdf_wren/app_wdf_end- MIG write-data strobes
//                wfifo_rden              - write FIFO pop (FWFT)
//                rfifo_wren              - read FIFO push
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_rw_arb
    import ddr3_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_STEP   = 8,
    parameter int WR_ADDR_MIN = 0,
    parameter int WR_ADDR_MAX = 1024*768,
    parameter int RD_ADDR_MIN = 0,
    parameter int RD_ADDR_MAX = 1024*768,
    parameter int RD_THRESH   = 512,
    parameter int BANK_BIT    = 24
)(
    input  logic                  clk_100,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic                  app_rd_data_valid,
    input  logic [FIFO_CNT_W-1:0] wfifo_rcount,
    input  logic [FIFO_CNT_W-1:0] rfifo_wcount,
    input  logic                  wr_load,
    input  logic                  rd_load,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic                  wfifo_rden,
    output logic                  rfifo_wren
);

    localparam logic [FIFO_CNT_W-1:0] c_BURST_LEN  = FIFO_CNT_W'(BURST_LEN);
    localparam logic [FIFO_CNT_W-1:0] c_BURST_LAST = FIFO_CNT_W'(BURST_LEN - 1);
    localparam logic [FIFO_CNT_W-1:0] c_RD_THRESH  = FIFO_CNT_W'(RD_THRESH);
    localparam logic [ADDR_W:0]       c_STEP       = (ADDR_W+1)'(ADDR_STEP);
    localparam logic [ADDR_W:0]       c_WR_MAX     = (ADDR_W+1)'(WR_ADDR_MAX);
    localparam logic [ADDR_W:0]       c_RD_MAX     = (ADDR_W+1)'(RD_ADDR_MAX);
    localparam logic [ADDR_W-1:0]     c_WR_MIN     = ADDR_W'(WR_ADDR_MIN);
    localparam logic [ADDR_W-1:0]     c_RD_MIN     = ADDR_W'(RD_ADDR_MIN);

    // Reject a bank-select bit that falls outside the address bus
    if (BANK_BIT >= ADDR_W) begin : g_bank_bit_check
        $error("BANK_BIT must be below ADDR_W");
    end

    state_t                r_state;
    logic [FIFO_CNT_W-1:0] r_beat_cnt;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic                  r_wr_pend;
    logic                  r_rd_pend;
    logic [ADDR_W-1:0]     r_addr_hold;
    logic [2:0]            r_cmd_hold;

    logic                  w_wr_load_pulse;
    logic                  w_rd_load_pulse;
    logic                  w_in_wr;
    logic                  w_in_rd;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_apply;
    logic                  w_last_beat;
    logic [ADDR_W:0]       w_wr_sum;
    logic [ADDR_W:0]       w_rd_sum;
    logic                  w_wr_wrap;
    logic                  w_rd_wrap;
    logic [ADDR_W-1:0]     w_wr_next;
    logic [ADDR_W-1:0]     w_rd_next;

`ifdef PINGPONG_EN
    logic                  r_wr_bank;
    logic                  r_rd_bank;
`endif

    load_edge_sync u_wr_load_sync (
        .clk     (clk_100),
        .rst     (rst),
        .i_async (wr_load),
        .o_pulse (w_wr_load_pulse)
    );

    load_edge_sync u_rd_load_sync (
        .clk     (clk_100),
        .rst     (rst),
        .i_async (rd_load),
        .o_pulse (w_rd_load_pulse)
    );

    // The command channel is only live while calibration holds, so a
    // calibration drop abandons the burst without popping or issuing.
    assign w_in_wr     = (r_state == WRITE) & init_calib_complete;
    assign w_in_rd     = (r_state == READ)  & init_calib_complete;
    assign w_wr_accept = w_in_wr & app_rdy & app_wdf_rdy;
    assign w_rd_accept = w_in_rd & app_rdy;
    assign w_last_beat = (r_beat_cnt == c_BURST_LAST);
    assign w_apply     = (r_state == ARB) & init_calib_complete & (r_wr_pend | r_rd_pend);

    // Pointer advance with wrap back to the region start
    assign w_wr_sum  = {1'b0, r_wr_ptr} + c_STEP;
    assign w_rd_sum  = {1'b0, r_rd_ptr} + c_STEP;
    assign w_wr_wrap = (w_wr_sum >= c_WR_MAX);
    assign w_rd_wrap = (w_rd_sum >= c_RD_MAX);
    assign w_wr_next = w_wr_wrap ? c_WR_MIN : w_wr_sum[ADDR_W-1:0];
    assign w_rd_next = w_rd_wrap ? c_RD_MIN : w_rd_sum[ADDR_W-1:0];

    // Address/command follow the active pointer; elsewhere they hold
    always_comb begin
        app_addr = r_addr_hold;
        app_cmd  = r_cmd_hold;
        if (w_in_wr) begin
            app_addr = r_wr_ptr;
`ifdef PINGPONG_EN
            app_addr[BANK_BIT] = r_wr_bank;
`endif
            app_cmd  = CMD_WR;
        end else if (w_in_rd) begin
            app_addr = r_rd_ptr;
`ifdef PINGPONG_EN
            app_addr[BANK_BIT] = r_rd_bank;
`endif
            app_cmd  = CMD_RD;
        end
    end

    // A write command is only offered together with its data beat
    assign app_en       = w_in_wr ? app_wdf_rdy : w_in_rd;
    assign app_wdf_wren = w_in_wr & app_wdf_rdy;
    assign app_wdf_end  = w_in_wr & app_wdf_rdy;
    assign wfifo_rden   = w_wr_accept;
    assign rfifo_wren   = app_rd_data_valid;

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_state     <= INIT;
            r_beat_cnt  <= '0;
            r_wr_ptr    <= c_WR_MIN;
            r_rd_ptr    <= c_RD_MIN;
            r_wr_pend   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_addr_hold <= '0;
            r_cmd_hold  <= CMD_WR;
        end else begin
            r_addr_hold <= app_addr;
            r_cmd_hold  <= app_cmd;
            // A new edge wins over a same-cycle clear so it is never lost
            r_wr_pend   <= (r_wr_pend & ~w_apply) | w_wr_load_pulse;
            r_rd_pend   <= (r_rd_pend & ~w_apply) | w_rd_load_pulse;

            if (!init_calib_complete) begin
                r_state    <= INIT;
                r_beat_cnt <= '0;
            end else begin
                case (r_state)
                    INIT: r_state <= ARB;
                    ARB: begin
                        // Pending frame restarts take one idle cycle first
                        if (w_apply) begin
                            if (r_wr_pend) r_wr_ptr <= c_WR_MIN;
                            if (r_rd_pend) r_rd_ptr <= c_RD_MIN;
                        end else if (wfifo_rcount >= c_BURST_LEN) begin
                            r_state <= WRITE;
                        end else if (rfifo_wcount < c_RD_THRESH) begin
                            r_state <= READ;
                        end
                    end
                    WRITE: begin
                        if (w_wr_accept) begin
                            r_wr_ptr <= w_wr_next;
                            if (w_last_beat) begin
                                r_beat_cnt <= '0;
                                r_state    <= ARB;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + FIFO_CNT_W'(1);
                            end
                        end
                    end
                    READ: begin
                        if (w_rd_accept) begin
                            r_rd_ptr <= w_rd_next;
                            if (w_last_beat) begin
                                r_beat_cnt <= '0;
                                r_state    <= ARB;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + FIFO_CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= INIT;
                endcase
            end
        end
    end

`ifdef PINGPONG_EN
    // Write bank flips per completed frame; read bank tracks the frame the
    // writer is not currently filling.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_wr_accept && w_wr_wrap) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if ((w_rd_accept && w_rd_wrap) || (w_apply && r_rd_pend)) begin
                r_rd_bank <= ~r_wr_bank;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rw_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_rw_arb
//  Description : Self-checking bench for ddr3_rw_arb. Random MIG handshakes
//                are checked against a transaction-level address model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_rw_arb;

    localparam int ADDR_W   = 28;
    localparam int BURST    = 64;
    localparam int STEP     = 8;
    localparam int WR_MIN   = 0;
    localparam int WR_MAX   = 1024;
    localparam int RD_MIN   = 256;
    localparam int RD_MAX   = 256 + 4096;
    localparam int THRESH   = 512;
    localparam int BANK_BIT = 24;

    logic              clk_100 = 1'b0;
    logic              rst;
    logic              init_calib_complete;
    logic              app_rdy;
    logic              app_wdf_rdy;
    logic              app_rd_data_valid;
    logic [10:0]       wfifo_rcount;
    logic [10:0]       rfifo_wcount;
    logic              wr_load;
    logic              rd_load;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              wfifo_rden;
    logic              rfifo_wren;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: next address per stream and frame banks
    int m_wr_ptr;
    int m_rd_ptr;
    bit m_wr_bank;
    bit m_rd_bank;

    always #5 clk_100 = ~clk_100;

    ddr3_rw_arb #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST),
        .ADDR_STEP   (STEP),
        .WR_ADDR_MIN (WR_MIN),
        .WR_ADDR_MAX (WR_MAX),
        .RD_ADDR_MIN (RD_MIN),
        .RD_ADDR_MAX (RD_MAX),
        .RD_THRESH   (THRESH),
        .BANK_BIT    (BANK_BIT)
    ) dut (
        .clk_100             (clk_100),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data_valid   (app_rd_data_valid),
        .wfifo_rcount        (wfifo_rcount),
        .rfifo_wcount        (rfifo_wcount),
        .wr_load             (wr_load),
        .rd_load             (rd_load),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .wfifo_rden          (wfifo_rden),
        .rfifo_wren          (rfifo_wren)
    );

    function automatic logic [ADDR_W-1:0] exp_addr(input int p, input bit bank);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(p);
        a[BANK_BIT] = bank;
        return a;
    endfunction

    task automatic model_reset();
        m_wr_ptr  = WR_MIN;
        m_rd_ptr  = RD_MIN;
        m_wr_bank = 1'b0;
        m_rd_bank = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    // Drives handshakes (mode 0: random, mode 1: app_rdy toggles) and checks
    // every cycle until the requested beats are accepted or budget expires.
    task automatic run_traffic(input int tgt_wr, input int tgt_rd, input int mode,
                               input int budget, output int nwr, output int nrd);
        int cyc;
        nwr = 0;
        nrd = 0;
        cyc = 0;
        while ((nwr < tgt_wr || nrd < tgt_rd) && cyc < budget) begin
            if (mode == 1) begin
                app_rdy     = (cyc % 2) == 0;
                app_wdf_rdy = 1'b1;
            end else begin
                app_rdy     = ($urandom % 4) != 0;
                app_wdf_rdy = ($urandom % 4) != 0;
            end
            app_rd_data_valid = $urandom % 2;
            @(negedge clk_100);
            n_total++;
            if (rfifo_wren !== app_rd_data_valid)
                $display("FAIL rfifo_wren: got %b expected %b", rfifo_wren, app_rd_data_valid);
            else n_pass++;
            if (app_en === 1'b1 && app_cmd === 3'b000) begin
                n_total++;
                if (app_addr !== exp_addr(m_wr_ptr, m_wr_bank))
                    $display("FAIL wr_addr: got %0h expected %0h", app_addr, exp_addr(m_wr_ptr, m_wr_bank));
                else n_pass++;
                n_total++;
                if ({app_wdf_wren, app_wdf_end, wfifo_rden} !== {1'b1, 1'b1, app_rdy})
                    $display("FAIL wr_strobes: got %b expected %b", {app_wdf_wren, app_wdf_end, wfifo_rden}, {2'b11, app_rdy});
                else n_pass++;
                if (app_rdy) begin
`ifdef PINGPONG_EN
                    if (m_wr_ptr + STEP >= WR_MAX) m_wr_bank = ~m_wr_bank;
`endif
                    m_wr_ptr = (m_wr_ptr + STEP >= WR_MAX) ? WR_MIN : m_wr_ptr + STEP;
                    nwr++;
                end
            end else if (app_en === 1'b1 && app_cmd === 3'b001) begin
                n_total++;
                if (app_addr !== exp_addr(m_rd_ptr, m_rd_bank))
                    $display("FAIL rd_addr: got %0h expected %0h", app_addr, exp_addr(m_rd_ptr, m_rd_bank));
                else n_pass++;
                n_total++;
                if ({app_wdf_wren, app_wdf_end, wfifo_rden} !== 3'b000)
                    $display("FAIL rd_strobes: got %b expected 000", {app_wdf_wren, app_wdf_end, wfifo_rden});
                else n_pass++;
                if (app_rdy) begin
`ifdef PINGPONG_EN
                    if (m_rd_ptr + STEP >= RD_MAX) m_rd_bank = ~m_wr_bank;
`endif
                    m_rd_ptr = (m_rd_ptr + STEP >= RD_MAX) ? RD_MIN : m_rd_ptr + STEP;
                    nrd++;
                end
            end else begin
                n_total++;
                if ({app_en, wfifo_rden, app_wdf_wren, app_wdf_end} !== 4'b0000)
                    $display("FAIL idle_strobes: got %b expected 0000 (cmd %b)",
                             {app_en, wfifo_rden, app_wdf_wren, app_wdf_end}, app_cmd);
                else n_pass++;
            end
            tick();
            cyc++;
        end
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b1;
        if (cyc >= budget) begin
            n_total++;
            $display("FAIL traffic_timeout: got wr=%0d rd=%0d expected wr=%0d rd=%0d", nwr, nrd, tgt_wr, tgt_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk_100);
        n_total++;
        if (app_en !== 1'b0) $display("FAIL reset_app_en: got %b expected 0", app_en); else n_pass++;
        n_total++;
        if (app_addr !== '0) $display("FAIL reset_app_addr: got %0h expected 0", app_addr); else n_pass++;
        n_total++;
        if (app_cmd !== 3'b000) $display("FAIL reset_app_cmd: got %b expected 000", app_cmd); else n_pass++;
        n_total++;
        if ({app_wdf_wren, app_wdf_end, wfifo_rden} !== 3'b000)
            $display("FAIL reset_strobes: got %b expected 000", {app_wdf_wren, app_wdf_end, wfifo_rden});
        else n_pass++;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_calib_gating();
        bit found;
        wfifo_rcount = 11'd100;
        app_wdf_rdy  = 1'b1;
        app_rdy      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100);
            n_total++;
            if (app_en !== 1'b0) $display("FAIL calib_gate_en: got %b expected 0 (cycle %0d)", app_en, i);
            else n_pass++;
            tick();
        end
        init_calib_complete = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            @(negedge clk_100);
            if (app_en === 1'b1) found = 1'b1;
            else tick();
        end
        n_total++;
        if (!found) begin
            $display("FAIL calib_start: got app_en=0 expected write within 2 cycles");
        end else begin
            n_pass++;
            n_total++;
            if (app_addr !== exp_addr(WR_MIN, 1'b0) || app_cmd !== 3'b000)
                $display("FAIL calib_first_cmd: got addr %0h cmd %b expected addr 0 cmd 000", app_addr, app_cmd);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_write_stalls();
        int nwr, nrd;
        wfifo_rcount = 11'd64;
        rfifo_wcount = 11'd1000;
        run_traffic(BURST, 0, 1, 400, nwr, nrd);
        wfifo_rcount = 11'd0;
        n_total++;
        if (nwr !== BURST || nrd !== 0 || m_wr_ptr !== 512)
            $display("FAIL write_stalls: got wr=%0d rd=%0d next=%0d expected wr=64 rd=0 next=512", nwr, nrd, m_wr_ptr);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_100);
            n_total++;
            if (app_en !== 1'b0) $display("FAIL write_stalls_idle: got %b expected 0", app_en); else n_pass++;
            tick();
        end
    endtask

    task automatic test_priority();
        int nwr, nrd;
        wfifo_rcount = 11'd64;
        rfifo_wcount = 11'd0;
        run_traffic(BURST, 0, 0, 1000, nwr, nrd);
        wfifo_rcount = 11'd0;
        n_total++;
        if (nwr !== BURST || nrd !== 0)
            $display("FAIL priority_write_first: got wr=%0d rd=%0d expected wr=64 rd=0", nwr, nrd);
        else n_pass++;
        run_traffic(0, BURST, 0, 1000, nwr, nrd);
        rfifo_wcount = 11'd512;
        n_total++;
        if (nwr !== 0 || nrd !== BURST)
            $display("FAIL priority_read_next: got wr=%0d rd=%0d expected wr=0 rd=64", nwr, nrd);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100);
            n_total++;
            if (app_en !== 1'b0) $display("FAIL read_threshold: got app_en %b expected 0", app_en); else n_pass++;
            tick();
        end
    endtask

    task automatic test_wrap();
        int nwr, nrd;
        // 128 beats so far; the next beat must wrap to WR_MIN
        wfifo_rcount = 11'd64;
        rfifo_wcount = 11'd1000;
        run_traffic(1, 0, 0, 200, nwr, nrd);
        n_total++;
        if (nwr !== 1 || m_wr_ptr !== WR_MIN + STEP)
            $display("FAIL wrap_first_beat: got wr=%0d next=%0d expected wr=1 next=%0d", nwr, m_wr_ptr, WR_MIN + STEP);
        else n_pass++;
        run_traffic(BURST - 1 + 2 * BURST, 0, 0, 2000, nwr, nrd);
        wfifo_rcount = 11'd0;
        n_total++;
        if (nwr !== 3 * BURST - 1 || nrd !== 0)
            $display("FAIL wrap_bursts: got wr=%0d rd=%0d expected wr=%0d rd=0", nwr, nrd, 3 * BURST - 1);
        else n_pass++;
    endtask

    task automatic test_load_mid_burst();
        int nwr, nrd;
        wfifo_rcount = 11'd0;
        rfifo_wcount = 11'd0;
        run_traffic(0, 10, 0, 200, nwr, nrd);
        rd_load = 1'b1;
        run_traffic(0, BURST - 10, 0, 1000, nwr, nrd);
        n_total++;
        if (nrd !== BURST - 10 || nwr !== 0 || m_rd_ptr === RD_MIN)
            $display("FAIL rd_load_burst_complete: got rd=%0d wr=%0d next=%0d expected rd=54 wr=0", nrd, nwr, m_rd_ptr);
        else n_pass++;
        // Restart applies between bursts
        m_rd_ptr = RD_MIN;
`ifdef PINGPONG_EN
        m_rd_bank = ~m_wr_bank;
`endif
        run_traffic(0, BURST, 0, 1000, nwr, nrd);
        rfifo_wcount = 11'd1000;
        rd_load = 1'b0;
        n_total++;
        if (nrd !== BURST) $display("FAIL rd_load_restart: got rd=%0d expected 64", nrd); else n_pass++;

        // Write restart while idle
        wr_load = 1'b1;
        repeat (8) tick();
        wr_load = 1'b0;
        m_wr_ptr = WR_MIN;
        wfifo_rcount = 11'd64;
        run_traffic(BURST, 0, 0, 1000, nwr, nrd);
        wfifo_rcount = 11'd0;
        n_total++;
        if (nwr !== BURST || nrd !== 0) $display("FAIL wr_load_restart: got wr=%0d rd=%0d expected 64/0", nwr, nrd);
        else n_pass++;
    endtask

    task automatic test_calib_drop();
        int nwr, nrd;
        wfifo_rcount = 11'd64;
        run_traffic(20, 0, 0, 400, nwr, nrd);
        init_calib_complete = 1'b0;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_100);
            n_total++;
            if (app_en !== 1'b0 || wfifo_rden !== 1'b0)
                $display("FAIL calib_drop_idle: got en=%b rden=%b expected 0/0", app_en, wfifo_rden);
            else n_pass++;
            tick();
        end
        init_calib_complete = 1'b1;
        // Fresh burst must last a full 64 beats even though the source dries up
        run_traffic(44, 0, 0, 400, nwr, nrd);
        wfifo_rcount = 11'd0;
        run_traffic(20, 0, 0, 400, nwr, nrd);
        n_total++;
        if (nwr !== 20 || nrd !== 0) $display("FAIL calib_drop_full_burst: got wr=%0d rd=%0d expected 20/0", nwr, nrd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int nwr, nrd;
        wfifo_rcount = 11'd64;
        run_traffic(30, 0, 0, 400, nwr, nrd);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk_100);
        n_total++;
        if ({app_en, wfifo_rden, app_wdf_wren} !== 3'b000 || app_addr !== '0 || app_cmd !== 3'b000)
            $display("FAIL rst_mid_burst: got en/rden/wren=%b addr=%0h cmd=%b expected 000/0/000",
                     {app_en, wfifo_rden, app_wdf_wren}, app_addr, app_cmd);
        else n_pass++;
        tick();
        @(negedge clk_100);
        n_total++;
        if (app_en !== 1'b0) $display("FAIL rst_arb_idle: got %b expected 0", app_en); else n_pass++;
        tick();
        run_traffic(BURST, 0, 0, 1000, nwr, nrd);
        wfifo_rcount = 11'd0;
        n_total++;
        if (nwr !== BURST || nrd !== 0) $display("FAIL rst_restart_burst: got wr=%0d rd=%0d expected 64/0", nwr, nrd);
        else n_pass++;
    endtask

    initial begin
        rst                 = 1'b1;
        init_calib_complete = 1'b0;
        app_rdy             = 1'b0;
        app_wdf_rdy         = 1'b0;
        app_rd_data_valid   = 1'b0;
        wfifo_rcount        = 11'd0;
        rfifo_wcount        = 11'd1000;
        wr_load             = 1'b0;
        rd_load             = 1'b0;
        model_reset();

        test_reset();
        test_calib_gating();
        test_write_stalls();
        test_priority();
        test_wrap();
        test_load_mid_burst();
        test_calib_drop();
        test_reset_mid_burst();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_rw_arb.md
Name: ddr3_rw_arb

Overview:
- Frame-buffer traffic controller between the write/read FIFO pair and the MIG user (app_*) interface.
- Watches wfifo_rcount and rfifo_wcount, and arbitrates fixed-length write and read bursts.
- Generates the wrapping DDR3 write and read addresses, and the FIFO pop/push strobes.
- Runs entirely in the MIG UI clock domain (clk_100).

Parameters:
- ADDR_W, 28: width of app_addr.
- BURST_LEN, 64: 256-bit beats per burst; must be a power of two and ≤ 1024.
- ADDR_STEP, 8: app_addr increment per 256-bit beat.
- WR_ADDR_MIN, 0: first write address (inclusive).
- WR_ADDR_MAX, 1024*768: write wrap bound (exclusive).
- RD_ADDR_MIN, 0: first read address (inclusive).
- RD_ADDR_MAX, 1024*768: read wrap bound (exclusive).
- RD_THRESH, 512: read burst allowed while rfifo_wcount < RD_THRESH.
- BANK_BIT, 24: app_addr bit that selects the frame bank (used only with PINGPONG_EN).

Ports:
- clk_100  in  1  MIG UI clock.
- rst  in  1  Synchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done.
- app_rdy  in  1  MIG command accept.
- app_wdf_rdy  in  1  MIG write-data accept.
- app_rd_data_valid  in  1  MIG read data valid.
- wfifo_rcount  in  11  Words available in the write FIFO.
- rfifo_wcount  in  11  Words held in the read FIFO.
- wr_load  in  1  Write-source frame restart; asynchronous to clk_100.
- rd_load  in  1  Display frame restart; asynchronous to clk_100.
- app_addr  out  ADDR_W  Command address.
- app_cmd  out  3  Command: 3'b000 = write, 3'b001 = read.
- app_en  out  1  Command valid.
- app_wdf_wren  out  1  Write data valid.
- app_wdf_end  out  1  Last write-data beat; equals app_wdf_wren (BL8, 256-bit).
- wfifo_rden  out  1  Write-FIFO pop. The write FIFO is first-word-fall-through; its dout drives app_wdf_data outside this block.
- rfifo_wren  out  1  Read-FIFO push; equals app_rd_data_valid. app_rd_data drives the FIFO din directly.

Behaviour:
- Reset values: app_addr 0; app_cmd 3'b000; app_en 0; app_wdf_wren 0; app_wdf_end 0; wfifo_rden 0; all counters 0; state INIT; both address pointers at their MIN; load-pending flags 0.
- Clock domain crossing:
  - wr_load and rd_load each pass through a 2-FF synchronizer, then a rising-edge detect.
  - A detected edge sets the matching pending flag.
- FSM states: INIT, ARB, WRITE, READ.
  - INIT -> ARB when init_calib_complete = 1.
  - ARB applies pending loads first: wr pointer <= WR_ADDR_MIN and/or rd pointer <= RD_ADDR_MIN; the flags clear. This takes one cycle in ARB with no command issued.
  - ARB -> WRITE if wfifo_rcount ≥ BURST_LEN (writes have priority).
  - Otherwise ARB -> READ if rfifo_wcount < RD_THRESH.
  - Otherwise the FSM stays in ARB.
  - WRITE/READ -> ARB on the accepted beat where beat_cnt == BURST_LEN-1; beat_cnt then clears.
- WRITE state:
  - app_cmd = 000.
  - app_en = app_wdf_wren = app_wdf_end = app_wdf_rdy (combinational).
  - A beat is accepted when app_rdy & app_wdf_rdy.
  - wfifo_rden = accept, in the same cycle (zero latency, FWFT).
  - On accept: wr pointer += ADDR_STEP, or reloads WR_ADDR_MIN if the result ≥ WR_ADDR_MAX; beat_cnt increments.
  - When not accepted, all outputs hold.
- READ state:
  - app_cmd = 001; app_en = 1; a command is accepted when app_rdy.
  - rd pointer advances and wraps as in WRITE, against RD_ADDR_MAX.
  - Read data return is decoupled; rfifo_wren follows app_rd_data_valid in every state.
- app_addr always drives the active pointer: the wr pointer in WRITE, the rd pointer in READ. It holds its last value elsewhere.
- A load pulse that arrives mid-burst stays pending; the burst is never truncated.
- init_calib_complete falling in any state forces INIT. Any in-flight burst is abandoned and beat_cnt clears.
- rst mid-burst returns all state and outputs to their reset values in the next cycle.
- ARB never starts a burst while rst = 1.

Optional Feature:
- Macro: PINGPONG_EN.
- When defined:
  - A 1-bit wr_bank register toggles on each write-pointer wrap.
  - On each read-pointer wrap, and on an applied rd_load, rd_bank <= ~wr_bank.
  - app_addr[BANK_BIT] is replaced by the active bank bit.
  - Both banks reset to 0.
- When undefined:
  - A single frame buffer is used; the bank registers do not exist and app_addr passes through unmodified.

Decomposition:
- Package ddr3_pkg holds:
  - the app_cmd constants CMD_WR = 3'b000 and CMD_RD = 3'b001;
  - the FSM state enum (INIT, ARB, WRITE, READ);
  - the shared count width FIFO_CNT_W = 11.
- One sub-module, load_edge_sync: a 2-FF synchronizer plus rising-edge pulse, instantiated twice (wr_load, rd_load).

Test Plan:
- Calibration gating: init_calib_complete = 0 and wfifo_rcount = 100 for 50 cycles -> app_en stays 0. Raise calib -> a write burst starts within 2 cycles at app_addr 0.
- Write with stalls: wfifo_rcount = 64, app_rdy toggling 1/0 each cycle -> exactly 64 wfifo_rden pulses, addresses 0..504 in steps of 8, then return to ARB.
- Priority: wfifo_rcount = 64 and rfifo_wcount = 0 in ARB together -> WRITE is chosen first, then READ. Then rfifo_wcount = 512 -> no read is issued.
- Wrap: WR_ADDR_MAX = 1024, BURST_LEN = 64 -> the 129th write beat issues address 0 (with PINGPONG_EN: app_addr[24] toggles 0 -> 1).
- Load mid-burst: rd_load pulse during beat 10 of a read burst -> all 64 beats complete; the next read burst starts at RD_ADDR_MIN.
- Reset mid-burst: rst for 1 cycle at beat 30 -> next cycle app_en = 0 and state INIT; after calib, the pointers restart at MIN.
